// File: rtl/sm_pkg.sv
// Shared definitions for the stepper-motor move controller.
//   - state_t   : move sequencer states
//   - SIZE_DEF  : default width of period values (matches the pulse generator's N)
//   - CNT_W_DEF : default width of the step counters
//   - sub_floor / add_ceil : saturating period arithmetic. The functions work on
//     32-bit values with a 33-bit intermediate, so SIZE may be at most 32.
package sm_pkg;

    localparam int SIZE_DEF  = 16;
    localparam int CNT_W_DEF = 24;

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        CRUISE,
        DECEL,
        STOP
    } state_t;

    // a - b, never below lo. The extra bit makes a borrow visible instead of
    // letting the difference wrap to a huge period.
    function automatic logic [31:0] sub_floor(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] lo);
        logic [32:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[32] || (diff[31:0] < lo)) return lo;
        return diff[31:0];
    endfunction

    // a + b, never above hi. The extra bit holds the carry so an overflow
    // cannot wrap to a small period.
    function automatic logic [31:0] add_ceil(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] hi);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, hi}) return hi;
        return sum[31:0];
    endfunction

endpackage

// File: rtl/sm_step_edge.sv
// Rising-edge detector for the pulse generator's step output.
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   step_i     : drv_step from the pulse generator
//   step_evt_o : one-cycle pulse in the first cycle step_i is seen high
module sm_step_edge (
    input  logic clk,
    input  logic rst,
    input  logic step_i,
    output logic step_evt_o
);

    logic step_q;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= step_i;
    end

    assign step_evt_o = step_i & ~step_q;

endmodule

// File: rtl/sm_move_ctrl.sv
// Motion sequencer in front of the stepper-motor pulse generator. Latches a
// move command, ramps the generator's period down to cruise and back up, and
// counts issued steps from the generator's feedback.
//   clk, rst                 : clock, synchronous active-high reset
//   start, abort             : one-cycle move request / controlled-stop request
//   target_steps, dir_in     : move length and direction
//   period_start, period_min : slowest (start/end) and fastest (cruise) period
//   accel_dec                : period change per step while ramping
//   drv_step_in              : step output fed back from the pulse generator
//   drv_enable_SM, period_N  : enable and period to the pulse generator
//   dir, busy, done, aborted : latched direction and move status
//   steps_issued             : steps counted in the current/last move
module sm_move_ctrl
    import sm_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] target_steps,
    input  logic             dir_in,
    input  logic [SIZE-1:0]  period_start,
    input  logic [SIZE-1:0]  period_min,
    input  logic [SIZE-1:0]  accel_dec,
    input  logic             drv_step_in,
    output logic             drv_enable_SM,
    output logic [SIZE-1:0]  period_N,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_issued
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, steps_q, ramp_q, ramp_d;
    logic [SIZE-1:0]  pstart_q, effmin_q, accel_q, period_q, period_d;
    logic             dir_q, busy_q, enable_q, done_q, aborted_q;
    logic             abort_flag_q, abort_flag_d;

    logic             step_evt;
    logic [CNT_W-1:0] steps_inc, remaining;
    logic [SIZE-1:0]  eff_min_in, period_acc, period_dec;
    logic             complete, running;

    sm_step_edge u_step_edge (
        .clk       (clk),
        .rst       (rst),
        .step_i    (drv_step_in),
        .step_evt_o(step_evt)
    );

    // The cruise period may never be slower than the start period; a
    // period_min above period_start collapses the move to a flat profile.
    assign eff_min_in = (period_min < period_start) ? period_min : period_start;

    // steps_q < target_q while running, so the increment cannot wrap and the
    // remaining count cannot go negative.
    assign steps_inc  = steps_q + CNT_W'(1);
    assign remaining  = target_q - steps_inc;
    assign complete   = step_evt && (steps_inc == target_q);
    assign running    = (state_q == ACCEL) || (state_q == CRUISE) || (state_q == DECEL);

    assign period_acc = SIZE'(sub_floor(32'(period_q), 32'(accel_q), 32'(effmin_q)));
    assign period_dec = SIZE'(add_ceil(32'(period_q), 32'(accel_q), 32'(pstart_q)));

    // Next values while a move runs. The step is applied first, then abort
    // acts on the post-step state.
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        period_d     = period_q;
        ramp_d       = ramp_q;
        state_d      = state_q;
        abort_flag_d = abort_flag_q || (abort && running && !complete);

        if (step_evt && (state_q == ACCEL)) begin
            period_d = period_acc;
            ramp_d   = ramp_q + CNT_W'(1);
        end else if (step_evt && (state_q == DECEL)) begin
            period_d = period_dec;
            ramp_d   = (ramp_q == '0) ? '0 : ramp_q - CNT_W'(1);
        end

        if (complete) begin
            state_d = STOP;
        end else begin
            // Decel is checked before cruise so a triangular profile wins a tie.
            if (step_evt && (state_q == ACCEL)) begin
                if (remaining <= ramp_d)        state_d = DECEL;
                else if (period_d == effmin_q)  state_d = CRUISE;
            end else if (step_evt && (state_q == CRUISE) && (remaining <= ramp_q)) begin
                state_d = DECEL;
            end
            if (abort && ((state_d == ACCEL) || (state_d == CRUISE))) state_d = DECEL;
            // An aborted move stops as soon as it is back at the start period.
            if ((state_d == DECEL) && abort_flag_d && (period_d == pstart_q)) state_d = STOP;
        end
    end

    // NOTE: every register, command latches included, is cleared by reset so
    // a reset mid-move leaves no stale command behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            target_q     <= '0;
            steps_q      <= '0;
            ramp_q       <= '0;
            pstart_q     <= '0;
            effmin_q     <= '0;
            accel_q      <= '0;
            period_q     <= '0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            enable_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_flag_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        target_q     <= target_steps;
                        dir_q        <= dir_in;
                        pstart_q     <= period_start;
                        effmin_q     <= eff_min_in;
                        accel_q      <= accel_dec;
                        period_q     <= period_start;
                        steps_q      <= '0;
                        ramp_q       <= '0;
                        abort_flag_q <= 1'b0;
                        aborted_q    <= 1'b0;
                        if (target_steps == '0) begin
                            // Nothing to move: report completion without enabling.
                            state_q <= STOP;
                            done_q  <= 1'b1;
                        end else begin
                            busy_q   <= 1'b1;
                            enable_q <= 1'b1;
                            state_q  <= ((accel_dec == '0) || (eff_min_in == period_start))
                                        ? CRUISE : ACCEL;
                        end
                    end
                end
                ACCEL, CRUISE, DECEL: begin
                    if (step_evt) steps_q <= steps_inc;
                    period_q     <= period_d;
                    ramp_q       <= ramp_d;
                    abort_flag_q <= abort_flag_d;
                    state_q      <= state_d;
                    if (state_d == STOP) begin
                        busy_q    <= 1'b0;
                        enable_q  <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= abort_flag_d;
                    end
                end
                default: state_q <= IDLE; // STOP: done is held for exactly this one cycle
            endcase
        end
    end

    assign drv_enable_SM = enable_q;
    assign period_N      = period_q;
    assign dir           = dir_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign steps_issued  = steps_q;

endmodule

// File: tb/tb_sm_move_ctrl.sv
// Directed testbench for sm_move_ctrl: trapezoid, triangle, abort, zero-length,
// flat (clamped) profile and reset mid-move. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_sm_move_ctrl;

    localparam int SIZE  = 16;
    localparam int CNT_W = 24;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] target_steps;
    logic             dir_in;
    logic [SIZE-1:0]  period_start;
    logic [SIZE-1:0]  period_min;
    logic [SIZE-1:0]  accel_dec;
    logic             drv_step_in;
    logic             drv_enable_SM;
    logic [SIZE-1:0]  period_N;
    logic             dir;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] steps_issued;

    int checks = 0;
    int errors = 0;

    // Hand-computed period after each step: 100/40 with slope 20.
    int trap_p [20] = '{80, 60, 40, 40, 40, 40, 40, 40, 40, 40,
                        40, 40, 40, 40, 40, 40, 40, 60, 80, 100};
    int tri_p  [4]  = '{80, 60, 80, 100};

    sm_move_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .target_steps (target_steps),
        .dir_in       (dir_in),
        .period_start (period_start),
        .period_min   (period_min),
        .accel_dec    (accel_dec),
        .drv_step_in  (drv_step_in),
        .drv_enable_SM(drv_enable_SM),
        .period_N     (period_N),
        .dir          (dir),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .steps_issued (steps_issued)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmd(input int tgt, input int ps, input int pm, input int ad, input logic d);
        @(negedge clk);
        target_steps = CNT_W'(tgt);
        period_start = SIZE'(ps);
        period_min   = SIZE'(pm);
        accel_dec    = SIZE'(ad);
        dir_in       = d;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // One generator step: high for one cycle, returns just after it was counted.
    task automatic step_once();
        @(negedge clk);
        drv_step_in = 1'b1;
        @(negedge clk);
        drv_step_in = 1'b0;
    endtask

    task automatic abort_pulse();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic check_start(input string name, input int ps, input logic d);
        check($sformatf("%s start busy", name), 32'(busy), 1);
        check($sformatf("%s start enable", name), 32'(drv_enable_SM), 1);
        check($sformatf("%s start period", name), 32'(period_N), ps);
        check($sformatf("%s start dir", name), 32'(dir), 32'(d));
        check($sformatf("%s start steps", name), 32'(steps_issued), 0);
        check($sformatf("%s start done", name), 32'(done), 0);
    endtask

    task automatic check_done(input string name, input int steps, input logic ab);
        check($sformatf("%s done", name), 32'(done), 1);
        check($sformatf("%s busy end", name), 32'(busy), 0);
        check($sformatf("%s enable end", name), 32'(drv_enable_SM), 0);
        check($sformatf("%s steps end", name), 32'(steps_issued), steps);
        check($sformatf("%s aborted", name), 32'(aborted), 32'(ab));
    endtask

    task automatic run_triangle(input string name);
        cmd(4, 100, 40, 20, 1'b0);
        check_start(name, 100, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step_once();
            check($sformatf("%s period step %0d", name, k), 32'(period_N), tri_p[k-1]);
            if (k < 4) check($sformatf("%s busy step %0d", name, k), 32'(busy), 1);
        end
        check_done(name, 4, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; drv_step_in = 1'b0;
        target_steps = '0; dir_in = 1'b0;
        period_start = '0; period_min = '0; accel_dec = '0;
        repeat (2) @(negedge clk);
        check("reset period", 32'(period_N), 0);
        check("reset busy", 32'(busy), 0);
        check("reset enable", 32'(drv_enable_SM), 0);
        check("reset done", 32'(done), 0);
        check("reset steps", 32'(steps_issued), 0);
        check("reset dir", 32'(dir), 0);
        check("reset aborted", 32'(aborted), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle done", 32'(done), 0);

        // Trapezoid, with a start request while busy that must be ignored.
        cmd(20, 100, 40, 20, 1'b1);
        check_start("trap", 100, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            step_once();
            if (k == 5) begin
                cmd(3, 50, 10, 5, 1'b0);
                check("trap start-while-busy dir", 32'(dir), 1);
                check("trap start-while-busy steps", 32'(steps_issued), 5);
                check("trap start-while-busy period", 32'(period_N), 40);
            end
            check($sformatf("trap period step %0d", k), 32'(period_N), trap_p[k-1]);
            check($sformatf("trap steps step %0d", k), 32'(steps_issued), k);
            if (k < 20) check($sformatf("trap done step %0d", k), 32'(done), 0);
        end
        check_done("trap", 20, 1'b0);
        @(negedge clk);
        check("trap done one cycle", 32'(done), 0);
        check("trap period held", 32'(period_N), 100);

        run_triangle("tri");

        // Abort in cruise after step 10.
        cmd(100, 100, 40, 20, 1'b0);
        check_start("abort", 100, 1'b0);
        for (int k = 1; k <= 10; k++) step_once();
        check("abort cruise period", 32'(period_N), 40);
        abort_pulse();
        check("abort busy after request", 32'(busy), 1);
        check("abort period unchanged", 32'(period_N), 40);
        check("abort done after request", 32'(done), 0);
        step_once();
        check("abort period step 11", 32'(period_N), 60);
        step_once();
        check("abort period step 12", 32'(period_N), 80);
        check("abort done step 12", 32'(done), 0);
        step_once();
        check("abort period step 13", 32'(period_N), 100);
        check_done("abort", 13, 1'b1);
        @(negedge clk);
        check("abort done one cycle", 32'(done), 0);
        check("abort flag held", 32'(aborted), 1);

        // Zero-length move; also clears the aborted flag.
        cmd(0, 100, 40, 20, 1'b0);
        check_done("zero", 0, 1'b0);
        @(negedge clk);
        check("zero done one cycle", 32'(done), 0);
        check("zero busy", 32'(busy), 0);
        check("zero enable", 32'(drv_enable_SM), 0);

        // period_min slower than period_start, huge slope: flat profile at 100.
        cmd(5, 100, 150, 500, 1'b1);
        check_start("flat", 100, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step_once();
            check($sformatf("flat period step %0d", k), 32'(period_N), 100);
        end
        check_done("flat", 5, 1'b0);

        // Reset mid-move at step 7.
        cmd(20, 100, 40, 20, 1'b1);
        for (int k = 1; k <= 7; k++) step_once();
        check("rst-move period step 7", 32'(period_N), 40);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst-move period", 32'(period_N), 0);
        check("rst-move busy", 32'(busy), 0);
        check("rst-move enable", 32'(drv_enable_SM), 0);
        check("rst-move done", 32'(done), 0);
        check("rst-move steps", 32'(steps_issued), 0);
        check("rst-move dir", 32'(dir), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst-move no done %0d", i), 32'(done), 0);
        end
        run_triangle("after-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
